// File: rtl/p2s_s2p_pkg.sv
// Shared definitions for the serializer link (transmit and receive sides).
//   COMMA         : idle/alignment symbol sent between data bytes
//   BIT_CNT_IDLE  : value of the 3-bit bit-select counter between bytes
//   state_t       : receiver alignment state
package p2s_s2p_pkg;

    localparam logic [7:0] COMMA        = 8'hBC;
    localparam logic [2:0] BIT_CNT_IDLE = 3'b111;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/s2p_shift_cnt.sv
// Serial-in shift register plus 3-bit bit counter for the receive side.
// Bits arrive LSB first, so each new bit enters at the top and the byte
// slides down toward bit 0.
//   CLK       : clock, rising edge
//   reset     : asynchronous, active-low
//   data_in   : serial data bit
//   valid_in  : data_in is a real bit this cycle
//   load_idle : on an accepted bit, force the counter to the idle value
//               (marks the current bit as the last bit of a byte)
//   window    : byte ending with the current bit, {data_in, shreg[7:1]}
//   byte_done : the current accepted bit completes a byte
module s2p_shift_cnt
    import p2s_s2p_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic       data_in,
    input  logic       valid_in,
    input  logic       load_idle,
    output logic [7:0] window,
    output logic       byte_done
);

    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    assign window    = {data_in, shreg[7:1]};
    // The bit that moves the counter onto the idle value ends a byte.
    assign byte_done = valid_in && (bit_cnt == 3'd6);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            shreg   <= 8'h00;
            bit_cnt <= BIT_CNT_IDLE;
        end else if (valid_in) begin
            shreg <= window;
            if (load_idle) begin
                bit_cnt <= BIT_CNT_IDLE;
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/s2p_comma_rx.sv
// Receive side of the serializer link. Deserializes a 1-bit LSB-first
// stream into bytes, hunts for the comma symbol to find byte boundaries,
// declares lock after LOCK_COUNT consecutive aligned commas and then
// presents each non-comma byte with a one-cycle valid strobe.
//   CLK       : clock, rising edge
//   reset     : asynchronous, active-low; clears all state
//   data_in   : serial data bit
//   valid_in  : data_in is a real bit this cycle; no bit consumed when 0
//   data_out  : last completed non-comma byte (bit 0 = first received bit)
//   valid_out : one-cycle strobe, data_out updated this cycle
//   active    : link locked (state ACTIVE)
//
// Handshake: valid_in qualifies data_in on every rising edge; there is no
// back-pressure. valid_out is a single-cycle strobe with no ready; the
// consumer must take data_out in the cycle valid_out is high.
module s2p_comma_rx
    import p2s_s2p_pkg::*;
#(
    parameter logic [7:0] COMMA      = p2s_s2p_pkg::COMMA,
    parameter int         LOCK_COUNT = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       data_in,
    input  logic       valid_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    state_t     state, state_next;
    logic [2:0] bc_cnt, bc_cnt_next;
    logic [7:0] data_out_next;
    logic       valid_out_next;
    logic       load_idle;
    logic [7:0] window;
    logic       byte_done;
    logic       is_comma;

    s2p_shift_cnt u_shift_cnt (
        .CLK       (CLK),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .load_idle (load_idle),
        .window    (window),
        .byte_done (byte_done)
    );

    assign is_comma = (window == COMMA);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            bc_cnt    <= 3'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_next;
            bc_cnt    <= bc_cnt_next;
            data_out  <= data_out_next;
            valid_out <= valid_out_next;
            active    <= (state_next == ACTIVE);
        end
    end

    always_comb begin
        state_next     = state;
        bc_cnt_next    = bc_cnt;
        data_out_next  = data_out;
        valid_out_next = 1'b0;
        load_idle      = 1'b0;

        unique case (state)
            SEARCH: begin
                // Sliding compare on every accepted bit; a hit defines the
                // byte boundary by parking the counter at idle.
                if (valid_in && is_comma) begin
                    load_idle   = 1'b1;
                    bc_cnt_next = 3'd1;
                    state_next  = (LOCK_COUNT == 1) ? ACTIVE : SYNC;
                end
            end

            SYNC: begin
                if (byte_done) begin
                    if (is_comma) begin
                        bc_cnt_next = bc_cnt + 3'd1;
                        if ((bc_cnt + 3'd1) == 3'(LOCK_COUNT)) begin
                            state_next = ACTIVE;
                        end
                    end else begin
                        // Counter keeps running; the sliding search picks
                        // up again from the next bit.
                        bc_cnt_next = 3'd0;
                        state_next  = SEARCH;
                    end
                end
            end

            ACTIVE: begin
                // No loss-of-lock detection; only reset leaves ACTIVE.
                if (byte_done && !is_comma) begin
                    data_out_next  = window;
                    valid_out_next = 1'b1;
                end
            end

            default: begin
                state_next = SEARCH;
            end
        endcase
    end

endmodule

// File: tb/tb_s2p_comma_rx.sv
// Self-checking bench for s2p_comma_rx: directed byte streams, expected
// output bytes queued at stimulus time and checked by a negedge monitor.
module tb_s2p_comma_rx;

    localparam logic [7:0] BC = 8'hBC;

    logic       CLK;
    logic       reset;
    logic       data_in;
    logic       valid_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    s2p_comma_rx #(
        .COMMA      (8'hBC),
        .LOCK_COUNT (4)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: run time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Present one bit; returns 1ns after the edge that sampled it, so the
    // registered outputs for that bit are already visible.
    task automatic drive_bit(input logic b, input logic v);
        data_in  = b;
        valid_in = v;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        data_in  = 1'b0;
        reset    = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid_out: actual data_out=%h required=no strobe", data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("data_out_on_strobe", data_out, e);
                check("active_on_strobe", {7'd0, active}, 8'd1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b0;
        data_in  = 1'b0;
        valid_in = 1'b1;

        // 1: reset, then 20 zero bits -> nothing happens
        repeat (3) @(posedge CLK);
        #1;
        check("reset_data_out", data_out, 8'h00);
        check("reset_valid_out", {7'd0, valid_out}, 8'd0);
        check("reset_active", {7'd0, active}, 8'd0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_bit(1'b0, 1'b1);
            check("zeros_idle_outputs", {data_out[6:0], valid_out | active}, 8'h00);
        end

        // 2: 3 arbitrary bits, BC x4, 5A, 3C
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) send_byte(BC);
        check("t2_active_before_4th_comma", {7'd0, active}, 8'd0);
        send_byte(BC);
        check("t2_active_after_4th_comma", {7'd0, active}, 8'd1);
        check("t2_no_output_for_lock_comma", data_out, 8'h00);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        idle(3);
        check("t2_all_bytes_seen", 8'(exp_q.size()), 8'd0);

        // 3: BC BC 12 breaks sync, then relock on BC x4, A7
        do_reset();
        send_byte(BC);
        send_byte(BC);
        send_byte(8'h12);
        check("t3_active_after_12", {7'd0, active}, 8'd0);
        for (int k = 0; k < 3; k++) send_byte(BC);
        check("t3_active_after_3_commas", {7'd0, active}, 8'd0);
        send_byte(BC);
        check("t3_active_relock", {7'd0, active}, 8'd1);
        exp_q.push_back(8'hA7);
        send_byte(8'hA7);
        idle(2);
        check("t3_all_bytes_seen", 8'(exp_q.size()), 8'd0);

        // 4: C3 with gaps before bits 2 and 6 (garbage on data_in during gaps)
        exp_q.push_back(8'hC3);
        for (int i = 0; i < 8; i++) begin
            if (i == 2 || i == 6) begin
                drive_bit(~(8'hC3 >> i), 1'b0);
                check("t4_no_strobe_in_gap", {7'd0, valid_out}, 8'd0);
            end
            drive_bit(8'(8'hC3 >> i) != 8'd0 ? (8'hC3 >> i) & 8'd1 : 1'b0, 1'b1);
        end
        idle(2);
        check("t4_all_bytes_seen", 8'(exp_q.size()), 8'd0);

        // 5: 11, BC, BC, 22
        exp_q.push_back(8'h11);
        send_byte(8'h11);
        send_byte(BC);
        send_byte(BC);
        check("t5_data_out_holds_over_commas", data_out, 8'h11);
        exp_q.push_back(8'h22);
        send_byte(8'h22);
        idle(2);
        check("t5_all_bytes_seen", 8'(exp_q.size()), 8'd0);

        // 6: async reset mid-byte of F0
        for (int i = 0; i < 4; i++) drive_bit(8'(8'hF0 >> i) & 8'd1, 1'b1);
        check("t6_data_out_before_reset", data_out, 8'h22);
        #3;
        reset = 1'b0;
        #1;
        check("t6_async_data_out", data_out, 8'h00);
        check("t6_async_active", {7'd0, active}, 8'd0);
        check("t6_async_valid_out", {7'd0, valid_out}, 8'd0);
        valid_in = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge CLK);
        #1;
        send_byte(8'h55);
        for (int k = 0; k < 3; k++) send_byte(BC);
        check("t6_active_after_3_commas", {7'd0, active}, 8'd0);
        send_byte(BC);
        check("t6_active_relock", {7'd0, active}, 8'd1);
        exp_q.push_back(8'h99);
        send_byte(8'h99);
        idle(3);
        check("t6_all_bytes_seen", 8'(exp_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
